// File: rtl/credit_sink_buffer.sv
// Receiver-side circular buffer behind the credit-gated FIFO: captures popped words,
// serves them over valid/ready, and returns one registered credit per drained word.
module credit_sink_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_rdy,
    output logic             credit_return,
    output logic [CNTW-1:0]  count,
    output logic             overflow_err
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             credit_q;
    logic             ovf_q, ovf_d;
    logic             full, empty, wr_en, deq;

    assign full  = (count_q == CNTW'(DEPTH));
    assign empty = (count_q == '0);
    // A full-buffer write is dropped even if the head drains this cycle: its credit
    // has not yet reached upstream, so the word was sent without a credit.
    assign wr_en = in_vld & ~full;
    assign deq   = ~empty & out_rdy;

    always_comb begin
        wptr_d  = wptr_q + PW'(wr_en);
        rptr_d  = rptr_q + PW'(deq);
        count_d = count_q + CNTW'(wr_en) - CNTW'(deq);
        ovf_d   = ovf_q | (in_vld & full);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            credit_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            credit_q <= deq;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= in_data;
        end
    end

    assign out_vld       = ~empty;
    assign out_data      = mem_q[rptr_q];
    assign credit_return = credit_q;
    assign count         = count_q;
    assign overflow_err  = ovf_q;
endmodule

// File: tb/tb_credit_sink_buffer.sv
// Bench for credit_sink_buffer: directed table, hand-written corner sequences and
// random traffic against a queue-based reference model.
module tb_credit_sink_buffer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_vld = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_rdy = 1'b0;
    logic             out_vld;
    logic [WIDTH-1:0] out_data;
    logic             credit_return;
    logic [CNTW-1:0]  count;
    logic             overflow_err;

    int n_cmp = 0;
    int n_err = 0;

    credit_sink_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data),
        .out_vld(out_vld), .out_data(out_data), .out_rdy(out_rdy),
        .credit_return(credit_return), .count(count), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [7:0] data;
        logic       rdy;
        logic       e_vld;
        logic       chk_data;
        logic [7:0] e_data;
        int         e_cnt;
        logic       e_cr;
        logic       e_ovf;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        in_vld  = v;
        in_data = d;
        out_rdy = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_vld = 1'b0;
        out_rdy = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    vec_t tbl[$];

    initial begin
        logic [7:0] q[$];
        logic       e_cr;
        logic       e_ovf;

        // vld data rdy | e_vld chk_data e_data e_cnt e_cr e_ovf
        tbl.push_back('{1, 8'hA5, 1, 1, 1, 8'hA5, 1, 0, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0});
        tbl.push_back('{1, 8'h01, 0, 1, 1, 8'h01, 1, 0, 0});
        tbl.push_back('{1, 8'h02, 0, 1, 1, 8'h01, 2, 0, 0});
        tbl.push_back('{1, 8'h03, 0, 1, 1, 8'h01, 3, 0, 0});
        tbl.push_back('{1, 8'h04, 0, 1, 1, 8'h01, 4, 0, 0});
        tbl.push_back('{1, 8'hFF, 0, 1, 1, 8'h01, 4, 0, 1});
        tbl.push_back('{0, 8'h00, 1, 1, 1, 8'h02, 3, 1, 1});
        tbl.push_back('{1, 8'h05, 0, 1, 1, 8'h02, 4, 0, 1});
        tbl.push_back('{1, 8'hEE, 1, 1, 1, 8'h03, 3, 1, 1});
        tbl.push_back('{0, 8'h00, 1, 1, 1, 8'h04, 2, 1, 1});
        tbl.push_back('{0, 8'h00, 1, 1, 1, 8'h05, 1, 1, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1});

        // reset then idle
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 8'h00, 0);
            chk("idle_vld", out_vld, 0);
            chk("idle_cnt", count, 0);
            chk("idle_cr", credit_return, 0);
            chk("idle_ovf", overflow_err, 0);
        end

        // directed table: single word, fill, overflow, wrap, drain
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].vld, tbl[i].data, tbl[i].rdy);
            chk($sformatf("tbl%0d_vld", i), out_vld, tbl[i].e_vld);
            if (tbl[i].chk_data) chk($sformatf("tbl%0d_data", i), out_data, tbl[i].e_data);
            chk($sformatf("tbl%0d_cnt", i), count, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_cr", i), credit_return, tbl[i].e_cr);
            chk($sformatf("tbl%0d_ovf", i), overflow_err, tbl[i].e_ovf);
        end

        // streaming: write and drain every cycle
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1, 8'(i + 8'h10), 1);
            chk("strm_cnt", count, 1);
            chk("strm_cr", credit_return, (i == 0) ? 0 : 1);
            chk("strm_data", out_data, i + 8'h10);
        end
        step(0, 8'h00, 1);
        chk("strm_end_cnt", count, 0);
        chk("strm_end_cr", credit_return, 1);
        chk("strm_ovf", overflow_err, 0);

        // mid-operation asynchronous reset with a credit in flight
        step(1, 8'h31, 0);
        step(1, 8'h32, 0);
        step(1, 8'h33, 0);
        step(1, 8'h34, 1);
        chk("mid_cnt_pre", count, 3);
        chk("mid_cr_pre", credit_return, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_vld", out_vld, 0);
        chk("mid_rst_cnt", count, 0);
        chk("mid_rst_cr", credit_return, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        step(0, 8'h00, 1);
        chk("mid_post_vld", out_vld, 0);
        chk("mid_post_cnt", count, 0);
        chk("mid_post_cr", credit_return, 0);
        step(1, 8'h77, 0);
        chk("mid_post_data", out_data, 8'h77);
        chk("mid_post_cnt1", count, 1);

        // random traffic against a queue model
        do_reset();
        q.delete();
        e_cr = 1'b0;
        e_ovf = 1'b0;
        for (int i = 0; i < 600; i++) begin
            logic       v, r, dq, full;
            logic [7:0] d;
            v = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            d = 8'($urandom);
            full = (q.size() == DEPTH);
            dq = (q.size() > 0) && r;
            if (v && full) e_ovf = 1'b1;
            if (dq) void'(q.pop_front());
            if (v && !full) q.push_back(d);
            e_cr = dq;
            step(v, d, r);
            chk("rnd_vld", out_vld, q.size() > 0);
            chk("rnd_cnt", count, q.size());
            chk("rnd_cr", credit_return, e_cr);
            chk("rnd_ovf", overflow_err, e_ovf);
            if (q.size() > 0) chk("rnd_data", out_data, q[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/credit_sink_buffer.md
Name: credit_sink_buffer

Overview:
- Receiver-side buffer that sits directly downstream of the credit-gated FIFO stage.
- Captures one word per cycle when the upstream stage pops (upstream qual_pop becomes in_vld here; upstream data_out becomes in_data).
- Holds words in a DEPTH-entry circular buffer and hands them to a consumer over a valid/ready handshake.
- Issues a one-cycle credit_return pulse for every word the consumer drains, keeping the upstream credit counter (CREDITS_MAX = DEPTH) consistent.

Parameters:
- WIDTH, `FIFO_DWIDTH, data word width in bits.
- DEPTH, `FIFO_DEPTH, buffer entries; must equal the upstream CREDITS_MAX; power of two, >= 2.
- CNTW, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_vld  input  1  upstream pop strobe; a word is transferred this cycle.
- in_data  input  WIDTH  upstream head-of-FIFO data, sampled when in_vld=1.
- out_vld  output  1  buffer holds at least one word.
- out_data  output  WIDTH  head word; combinational from storage, valid while out_vld=1.
- out_rdy  input  1  consumer accepts the head word when out_vld & out_rdy.
- credit_return  output  1  registered one-cycle pulse, one per drained word.
- count  output  CNTW  current occupancy, 0..DEPTH.
- overflow_err  output  1  sticky flag: in_vld arrived while the buffer was full.

Behaviour:
- Reset (rst=0, asynchronous): write pointer, read pointer and count go to 0; out_vld=0; credit_return=0; overflow_err=0. Storage contents are don't-care. Reset asserted mid-operation discards all buffered words immediately.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. full = (count==DEPTH); empty = (count==0).
- Write: when in_vld=1 and not full, storage[wptr] <= in_data and wptr increments. The word is visible on out_data the next cycle (latency 1).
- Write when full: the word is dropped, pointers and count are unchanged, and overflow_err <= 1. overflow_err stays set until reset. Full means every upstream credit is consumed, so this is always a protocol violation. A same-cycle drain does not legalise it, because the credit for that drain returns one cycle later.
- Drain: deq = out_vld & out_rdy. When deq=1, rptr increments. out_vld = !empty.
- out_data = storage[rptr] and is stable while out_vld=1 and out_rdy=0.
- Simultaneous write and deq when not full and not empty: both pointers advance and count is unchanged.
- Simultaneous write and deq when empty: impossible, since out_vld=0 means no deq. The word is written and count becomes 1.
- count update: count <= count + (write accepted) - deq.
- credit_return <= deq, registered. It pulses exactly one cycle after each drain. Back-to-back drains give back-to-back pulses with no coalescing and no drops.
- Credit conservation invariant: (upstream credit counter value) + count + (credit_return in flight) == DEPTH at every cycle after reset. The formal harness checks this.
- No combinational path from in_vld or in_data to credit_return or out_vld.

Test Plan:
- Reset then idle: assert rst=0 for 2 cycles, release, hold in_vld=0 for 5 cycles -> out_vld=0, count=0, credit_return=0, overflow_err=0 throughout.
- Single word: in_vld=1 with in_data=0xA5 for one cycle, out_rdy=1 -> next cycle out_vld=1 and out_data=0xA5; count goes 1 then 0; credit_return=1 for exactly one cycle, one cycle after the handshake.
- Fill and wrap: DEPTH=4, out_rdy=0, write 1,2,3,4 -> count=4. Drain one, write 5, then drain all -> outputs appear in order 1,2,3,4,5 and 5 credit pulses are observed.
- Overflow: fill to 4, then in_vld=1 with data 0xFF -> overflow_err=1 and stays set, count stays 4, 0xFF never appears on out_data.
- Streaming: in_vld=1 and out_rdy=1 every cycle for 20 cycles with incrementing data -> count holds at 1, credit_return is high every cycle after the first drain, data arrives in order.
- Mid-operation reset: with 3 words buffered, pulse rst low asynchronously between clock edges -> out_vld, count and credit_return clear immediately without waiting for a clock edge; no stale data appears after release.
